irq_controller: RTL
===================

# irq_controller

Avalon-MM interrupt aggregator sitting directly downstream of the timer blocks (and other peripherals): it collects up to 32 interrupt lines such as the timers' `coe_interrupt`, latches them as pending, applies a software mask, and drives one combined interrupt to the CPU. It also reports the lowest-numbered active source so the handler can dispatch without scanning.

## Interface
- `NUM_SOURCES`, default 8: number of interrupt inputs, legal range 1..32.
- `SYNC_STAGES`, default 2: synchronizer depth per input. 0 means bypass, for same-clock sources.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset: asynchronous, active-low.
- `avmms_address`  in  3  word address.
- `avmms_write`  in  1  write strobe.
- `avmms_writedata`  in  32  write data.
- `avmms_byteenable`  in  4  byte lanes for writes.
- `avmms_read`  in  1  read strobe. Informational only; it has no side effects.
- `avmms_readdata`  out  32  registered read data, valid the cycle after the address is presented. Reset value 0.
- `irq_in`  in  NUM_SOURCES  interrupt request lines, active-high, possibly asynchronous.
- `coe_irq`  out  1  combined interrupt to the CPU, registered. Reset value 0.

## Operation
Register map. Only bits `[NUM_SOURCES-1:0]` exist; other bits read 0 and ignore writes. Writes honour `byteenable` per byte.
- 0 PENDING, R/W1C: pending flags.
- 1 MASK, R/W: 1 means the source is enabled. Reset value 0.
- 2 MODE, R/W: 1 means edge mode, 0 means level mode. Reset value 0.
- 3 RAW, R: synchronized input levels.
- 4 CLAIM, R:
  - bit 31: any source is both pending and enabled.
  - bits [4:0]: index of the lowest-numbered pending and enabled source, or 0 when bit 31 is 0.
- 5 FORCE, W: writing 1 sets the pending flag of an edge-mode source. Reads return 0.
- 6, 7: read 0; writes ignored.

Per-source behaviour:
- Synchronizer: `SYNC_STAGES` flops produce `sync`. A `prev` flop holds last cycle's `sync`.
- Edge mode:
  - `pending` is set on `sync & ~prev` or on a FORCE write.
  - `pending` is cleared by a PENDING write with a 1 in that bit.
  - Set and clear in the same cycle: set wins.
- Level mode:
  - `pending <= sync` every cycle.
  - W1C and FORCE writes are ignored.
- Mode change: `pending` keeps its current value. `prev` is always updated, so switching modes never creates a spurious edge.
- Output: `coe_irq <= |(pending & MASK)`. Masking does not clear `pending`; unmasking a pending source raises `coe_irq`.
- CLAIM is computed combinationally from `pending & MASK` and captured through the readdata register.

## Timing
- Reset: all flops clear to 0, including synchronizers, `prev`, `pending`, MASK, MODE, `coe_irq` and `avmms_readdata`.
- Reset mid-operation: all pending interrupts are lost.
- Latency from `irq_in` to `coe_irq`: with `irq_in` sampled high at edge k (source enabled, edge or level mode):
  - `sync` is high after edge k+SYNC_STAGES−1.
  - `pending` is set at edge k+SYNC_STAGES.
  - `coe_irq` rises at edge k+SYNC_STAGES+1.
  - With `SYNC_STAGES`=0, `sync` = `irq_in`.
- Clear latency: a W1C write at edge w clears `pending` at w. `coe_irq` falls at w+1 unless a new edge lands at w, in which case set wins.
- Reads: `avmms_readdata` is registered from the address every cycle. Data is valid one cycle after the address. Register values reflect state before any write in the same cycle.
- Edges: an input pulse shorter than one clock may be missed when asynchronous. Two edges that arrive before the pending flag is cleared collapse into one.

## Structure
- Package `irq_controller_pkg`:
  - address constants `ADDR_PENDING` through `ADDR_FORCE`.
  - `CLAIM_VALID_BIT` = 31.
- Sub-module `irq_input_stage`, one instance per source: synchronizer, `prev` flop, edge/level pending logic. Ports: the synchronized level and the pending flag.
- Top level holds the MASK and MODE registers, the output register, the priority encoder and the read mux.

## Test plan
- Edge mode, source 3: MODE=0x08, MASK=0x08, pulse `irq_in[3]` for 1 cycle.
  - `coe_irq` rises SYNC_STAGES+1 cycles after the sample edge.
  - PENDING=0x08. CLAIM=0x8000_0003.
  - Writing PENDING=0x08 drops `coe_irq` one cycle later.
- Level mode, source 0: MASK=0x01, hold `irq_in[0]` high.
  - A write of PENDING=0x01 has no effect; `coe_irq` stays 1.
  - Deasserting the input drops `coe_irq` SYNC_STAGES+1 cycles later.
- Masking: sources 1 and 5 pending in edge mode, MASK=0x00.
  - `coe_irq`=0. CLAIM=0x0000_0000.
  - MASK=0x20 gives CLAIM=0x8000_0005 and `coe_irq`=1 one cycle later.
- Simultaneous set and clear: an edge on source 2 lands in the same cycle as a W1C of bit 2 → PENDING bit 2 stays 1.
- FORCE: FORCE=0x81 with MODE=0xFF, MASK=0xFF.
  - PENDING=0x81, CLAIM index 0.
  - W1C of 0x01 gives CLAIM index 7.
- Reset mid-operation: assert `reset_n` low while PENDING=0xFF → all registers, `coe_irq` and `avmms_readdata` read 0 after release.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg
//   Shared constants for the interrupt aggregator: Avalon-MM word addresses,
//   the CLAIM valid-bit position and a byte-enable expansion helper.
package irq_controller_pkg;

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_MASK    = 3'd1;
   localparam logic [2:0] ADDR_MODE    = 3'd2;
   localparam logic [2:0] ADDR_RAW     = 3'd3;
   localparam logic [2:0] ADDR_CLAIM   = 3'd4;
   localparam logic [2:0] ADDR_FORCE   = 3'd5;

   localparam int CLAIM_VALID_BIT = 31;

   // Expands a 4-bit byteenable into a 32-bit per-bit write mask.
   function automatic logic [31:0] byte_mask(input logic [3:0] be);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) begin
         m[b*8 +: 8] = {8{be[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/irq_input_stage.sv
// irq_input_stage
//   One interrupt source: SYNC_STAGES-deep synchronizer, a prev flop for
//   rising-edge detection, and the edge/level pending flag.
// Ports
//   clk, reset_n  clock, asynchronous active-low reset
//   irq_in        raw (possibly asynchronous) request line
//   edge_mode     1 = edge mode, 0 = level mode
//   force_set     FORCE write with a 1 in this bit (edge mode only)
//   w1c_clr       PENDING write with a 1 in this bit (edge mode only)
//   sync_level    synchronized input level
//   pending       pending flag
module irq_input_stage
   import irq_controller_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic irq_in,
   input  logic edge_mode,
   input  logic force_set,
   input  logic w1c_clr,
   output logic sync_level,
   output logic pending
);

   logic prev;
   logic rise;

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign sync_level = irq_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;

         // NOTE: state is updated with non-blocking assignments so every flop
         // samples the pre-edge value of its neighbour, giving a true shift chain.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= irq_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign sync_level = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign rise = sync_level & ~prev;

   // prev tracks sync in both modes so a mode switch never fabricates an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev    <= 1'b0;
         pending <= 1'b0;
      end else begin
         prev <= sync_level;
         if (edge_mode) begin
            // Clear first, then set: a same-cycle edge or FORCE wins over W1C.
            pending <= (pending & ~w1c_clr) | rise | force_set;
         end else begin
            pending <= sync_level;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// irq_controller
//   Avalon-MM interrupt aggregator. Latches up to 32 sources as pending,
//   masks them, drives one registered CPU interrupt and reports the
//   lowest-numbered active source through the CLAIM register.
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   avmms_address       word address (0 PENDING, 1 MASK, 2 MODE, 3 RAW,
//                       4 CLAIM, 5 FORCE, 6-7 reserved)
//   avmms_write         write strobe
//   avmms_writedata     write data
//   avmms_byteenable    byte lanes for writes
//   avmms_read          read strobe (no side effects)
//   avmms_readdata      registered read data, valid one cycle after address
//   irq_in              interrupt request lines, active-high
//   coe_irq             combined registered interrupt to the CPU
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int NUM_SOURCES = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [2:0]             avmms_address,
   input  logic                   avmms_write,
   input  logic [31:0]            avmms_writedata,
   input  logic [3:0]             avmms_byteenable,
   input  logic                   avmms_read,
   output logic [31:0]            avmms_readdata,
   input  logic [NUM_SOURCES-1:0] irq_in,
   output logic                   coe_irq
);

   logic [NUM_SOURCES-1:0] mask_q;
   logic [NUM_SOURCES-1:0] mode_q;
   logic [NUM_SOURCES-1:0] raw;
   logic [NUM_SOURCES-1:0] pending;
   logic [NUM_SOURCES-1:0] active;
   logic [NUM_SOURCES-1:0] be_bits;
   logic [NUM_SOURCES-1:0] wr_bits;
   logic [NUM_SOURCES-1:0] w1c_clr;
   logic [NUM_SOURCES-1:0] force_set;
   logic [31:0]            be_bits32;
   logic [31:0]            rd_next;
   logic [4:0]             claim_idx;
   logic                   claim_valid;
   logic                   unused_bits;

   assign be_bits32 = byte_mask(avmms_byteenable);
   assign be_bits   = be_bits32[NUM_SOURCES-1:0];
   assign wr_bits   = avmms_writedata[NUM_SOURCES-1:0] & be_bits;

   assign w1c_clr   = (avmms_write && avmms_address == ADDR_PENDING) ? wr_bits : '0;
   assign force_set = (avmms_write && avmms_address == ADDR_FORCE)   ? wr_bits : '0;

   // Read strobe and bits above NUM_SOURCES have no function.
   assign unused_bits = ^{avmms_read, avmms_writedata, be_bits32};

   generate
      for (genvar s = 0; s < NUM_SOURCES; s++) begin : g_src
         irq_input_stage #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_stage (
            .clk        (clk),
            .reset_n    (reset_n),
            .irq_in     (irq_in[s]),
            .edge_mode  (mode_q[s]),
            .force_set  (force_set[s]),
            .w1c_clr    (w1c_clr[s]),
            .sync_level (raw[s]),
            .pending    (pending[s])
         );
      end
   endgenerate

   assign active      = pending & mask_q;
   assign claim_valid = |active;

   // Scanning downward leaves the lowest-numbered active index.
   always_comb begin
      // NOTE: claim_idx gets a default before the loop so no path leaves it
      // unassigned, which would otherwise infer a latch.
      claim_idx = '0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (active[i]) begin
            claim_idx = 5'(i);
         end
      end
   end

   always_comb begin
      rd_next = '0;
      case (avmms_address)
         ADDR_PENDING: rd_next = 32'(pending);
         ADDR_MASK:    rd_next = 32'(mask_q);
         ADDR_MODE:    rd_next = 32'(mode_q);
         ADDR_RAW:     rd_next = 32'(raw);
         ADDR_CLAIM: begin
            rd_next[CLAIM_VALID_BIT] = claim_valid;
            rd_next[4:0]             = claim_idx;
         end
         default:      rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q         <= '0;
         mode_q         <= '0;
         coe_irq        <= 1'b0;
         avmms_readdata <= '0;
      end else begin
         if (avmms_write && avmms_address == ADDR_MASK) begin
            mask_q <= (mask_q & ~be_bits) | wr_bits;
         end
         if (avmms_write && avmms_address == ADDR_MODE) begin
            mode_q <= (mode_q & ~be_bits) | wr_bits;
         end
         coe_irq        <= claim_valid;
         avmms_readdata <= rd_next;
      end
   end

endmodule
